// File: rtl/pipeline_pkg.sv
// pipeline_pkg: opcodes, ALU codes, write-back codes and the control bundle
// shared by the RV32 decode stage.
package pipeline_pkg;
    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_SLL   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;
    localparam logic [3:0] ALU_SRA   = 4'b1101;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_sel_t;

    typedef struct packed {
        logic       alusrc_b;
        logic       branch;
        logic       jump;
        logic       reg_write;
        logic       mem_rw;
        logic       illegal;
        logic [1:0] mem_to_reg;
        logic [3:0] alu_ctrl;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{alusrc_b: 1'b0, branch: 1'b0, jump: 1'b0, reg_write: 1'b0,
                                   mem_rw: 1'b0, illegal: 1'b0, mem_to_reg: WB_ALU, alu_ctrl: ALU_ADD};

    // alt is inst[30]: SUB on funct3 000, SRA on funct3 101
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/id_decoder.sv
// id_decoder: combinational RV32 decode of one instruction into controls,
// sign-extended immediate, source-use flags and the illegal flag.
module id_decoder
    import pipeline_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit EXT_EN = 1'b1
) (
    input  logic [31:0]     inst,
    output ctrl_t           ctrl,
    output logic [XLEN-1:0] imm,
    output logic            use_rs1,
    output logic            use_rs2
);
    logic [4:0] opcode;
    logic [2:0] funct3;
    logic       ext_f3;
    logic       known;
    logic       legal;
    logic       rs1_u;
    logic       rs2_u;
    imm_sel_t   imm_sel;
    ctrl_t      dec;

    assign opcode = inst[6:2];
    assign funct3 = inst[14:12];
    assign ext_f3 = funct3 inside {3'b001, 3'b011, 3'b101};

    always_comb begin
        dec = CTRL_NOP;
        imm_sel = IMM_I;
        rs1_u = 1'b0;
        rs2_u = 1'b0;
        known = 1'b1;
        case (opcode)
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.alu_ctrl = alu_from_funct3(funct3, inst[30]);
                rs1_u = 1'b1;
                rs2_u = 1'b1;
                known = EXT_EN || !ext_f3;
            end
            OP_IMM: begin
                dec.alusrc_b = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_ctrl = alu_from_funct3(funct3, inst[30] && funct3 != 3'b000);
                rs1_u = 1'b1;
                known = EXT_EN || !ext_f3;
            end
            OP_LOAD: begin
                dec.alusrc_b = 1'b1;
                dec.reg_write = 1'b1;
                dec.mem_to_reg = WB_MEM;
                rs1_u = 1'b1;
            end
            OP_STORE: begin
                dec.alusrc_b = 1'b1;
                dec.mem_rw = 1'b1;
                imm_sel = IMM_S;
                rs1_u = 1'b1;
                rs2_u = 1'b1;
            end
            OP_BRANCH: begin
                dec.branch = 1'b1;
                dec.alu_ctrl = ALU_SUB;
                imm_sel = IMM_B;
                rs1_u = 1'b1;
                rs2_u = 1'b1;
            end
            OP_JAL: begin
                dec.jump = 1'b1;
                dec.reg_write = 1'b1;
                dec.mem_to_reg = WB_PC4;
                imm_sel = IMM_J;
            end
            OP_JALR: begin
                dec.jump = 1'b1;
                dec.reg_write = 1'b1;
                dec.mem_to_reg = WB_PC4;
                dec.alusrc_b = 1'b1;
                rs1_u = 1'b1;
                known = EXT_EN;
            end
            OP_LUI: begin
                dec.alusrc_b = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_ctrl = ALU_PASSB;
                imm_sel = IMM_U;
                known = EXT_EN;
            end
            OP_AUIPC: begin
                dec.alusrc_b = 1'b1;
                dec.reg_write = 1'b1;
                imm_sel = IMM_U;
                known = EXT_EN;
            end
            default: known = 1'b0;
        endcase
    end

    // 16-bit encodings (inst[1:0] != 11) are not supported and count as illegal
    assign legal   = known && inst[1:0] == 2'b11;
    assign use_rs1 = legal && rs1_u;
    assign use_rs2 = legal && rs2_u;

    always_comb begin
        ctrl = dec;
        if (!legal) begin
            ctrl = CTRL_NOP;
            ctrl.illegal = 1'b1;
        end
    end

    assign imm = imm_sel == IMM_S ? XLEN'($signed({inst[31:25], inst[11:7]})) :
                 imm_sel == IMM_B ? XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0})) :
                 imm_sel == IMM_J ? XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0})) :
                 imm_sel == IMM_U ? XLEN'($signed({inst[31:12], 12'b0})) :
                                    XLEN'($signed(inst[31:20]));
endmodule

// File: rtl/pipeline_id_ex_stage.sv
// pipeline_id_ex_stage: RV32 decode stage with load-use hazard detection,
// flush/hold handling, the ID/EX register and a saturating bubble counter.
module pipeline_id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit EXT_EN    = 1'b1,
    parameter bit HAZARD_EN = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid_i,
    input  logic [31:0]      inst_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic             flush_i,
    input  logic             ex_stall_i,
    output logic             stall_o,
    output logic [4:0]       id_rs1_addr_o,
    output logic [4:0]       id_rs2_addr_o,
    output logic             ex_valid_o,
    output logic [XLEN-1:0]  ex_pc_o,
    output logic [4:0]       ex_rs1_addr_o,
    output logic [4:0]       ex_rs2_addr_o,
    output logic [4:0]       ex_rd_addr_o,
    output logic [XLEN-1:0]  ex_imm_o,
    output logic             ALUSrc_B,
    output logic             Branch,
    output logic             Jump,
    output logic             RegWrite,
    output logic             MemRW,
    output logic             illegal_o,
    output logic [1:0]       MemtoReg,
    output logic [3:0]       ALU_Control,
    output logic [CNT_W-1:0] bubble_cnt_o
);
    ctrl_t           dec_ctrl;
    ctrl_t           ex_ctrl;
    logic [XLEN-1:0] dec_imm;
    logic            use_rs1;
    logic            use_rs2;
    logic            load_use;
    logic            advance;
    logic            take;

    id_decoder #(.XLEN(XLEN), .EXT_EN(EXT_EN)) u_dec (
        .inst    (inst_i),
        .ctrl    (dec_ctrl),
        .imm     (dec_imm),
        .use_rs1 (use_rs1),
        .use_rs2 (use_rs2)
    );

    assign id_rs1_addr_o = inst_i[19:15];
    assign id_rs2_addr_o = inst_i[24:20];

    assign load_use = HAZARD_EN && id_valid_i && ex_valid_o && ex_ctrl.mem_to_reg == WB_MEM &&
                      ex_ctrl.reg_write && ex_rd_addr_o != 5'd0 &&
                      ((use_rs1 && ex_rd_addr_o == id_rs1_addr_o) ||
                       (use_rs2 && ex_rd_addr_o == id_rs2_addr_o));

    // flush kills ID, so it also cancels any hold or hazard stall
    assign stall_o = !flush_i && (ex_stall_i || load_use);
    assign advance = flush_i || !ex_stall_i;
    assign take    = id_valid_i && !flush_i && !load_use;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_o    <= 1'b0;
            ex_pc_o       <= '0;
            ex_rs1_addr_o <= 5'd0;
            ex_rs2_addr_o <= 5'd0;
            ex_rd_addr_o  <= 5'd0;
            ex_imm_o      <= '0;
            ex_ctrl       <= CTRL_NOP;
            bubble_cnt_o  <= '0;
        end else begin
            if (advance) begin
                ex_valid_o    <= take;
                ex_pc_o       <= take ? pc_i : '0;
                ex_rs1_addr_o <= take ? inst_i[19:15] : 5'd0;
                ex_rs2_addr_o <= take ? inst_i[24:20] : 5'd0;
                ex_rd_addr_o  <= take ? inst_i[11:7] : 5'd0;
                ex_imm_o      <= take ? dec_imm : '0;
                ex_ctrl       <= take ? dec_ctrl : CTRL_NOP;
            end
            if (advance && !flush_i && load_use && !(&bubble_cnt_o))
                bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
        end
    end

    assign ALUSrc_B    = ex_ctrl.alusrc_b;
    assign Branch      = ex_ctrl.branch;
    assign Jump        = ex_ctrl.jump;
    assign RegWrite    = ex_ctrl.reg_write;
    assign MemRW       = ex_ctrl.mem_rw;
    assign illegal_o   = ex_ctrl.illegal;
    assign MemtoReg    = ex_ctrl.mem_to_reg;
    assign ALU_Control = ex_ctrl.alu_ctrl;
endmodule

// File: tb/tb_pipeline_id_ex_stage.sv
// tb_pipeline_id_ex_stage: directed table, async-reset sequence and random run
// against a reference model; instance a is full-featured, instance b has EXT_EN=0 and a 2-bit counter.
module tb_pipeline_id_ex_stage;
    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        alusrc;
        logic        branch;
        logic        jump;
        logic        regw;
        logic        memrw;
        logic        ill;
        logic [1:0]  m2r;
        logic [3:0]  alu;
        logic [15:0] cnt;
    } bundle_t;

    typedef struct {
        logic        valid;
        logic [31:0] inst;
        logic        flush;
        logic        hold;
        logic        e_stall;
        logic        e_valid;
        logic        e_regw;
        logic        e_branch;
        logic        e_ill;
        logic [3:0]  e_alu;
        logic [4:0]  e_rd;
        logic [31:0] e_imm;
        logic [15:0] e_cnt;
        logic        b_regw;
        logic        b_ill;
    } row_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [31:0] inst = 32'h0;
    logic [31:0] pc = 32'h0;
    logic        flush = 1'b0;
    logic        hold = 1'b0;

    logic        a_stall, a_valid, a_alusrc, a_branch, a_jump, a_regw, a_memrw, a_ill;
    logic [4:0]  a_irs1, a_irs2, a_rs1, a_rs2, a_rd;
    logic [31:0] a_pc, a_imm;
    logic [1:0]  a_m2r;
    logic [3:0]  a_alu;
    logic [15:0] a_cnt;
    logic        b_stall, b_valid, b_alusrc, b_branch, b_jump, b_regw, b_memrw, b_ill;
    logic [4:0]  b_irs1, b_irs2, b_rs1, b_rs2, b_rd;
    logic [31:0] b_pc, b_imm;
    logic [1:0]  b_m2r;
    logic [3:0]  b_alu;
    logic [1:0]  b_cnt;

    int vecs = 0;
    int errs = 0;
    bundle_t m [2];
    row_t tbl [14];
    logic [4:0] ops [13] = '{5'b01100, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b01000, 5'b11000,
                             5'b11011, 5'b11001, 5'b01101, 5'b00101, 5'b11111, 5'b00011};

    always #5 clk = ~clk;

    pipeline_id_ex_stage dut_a (
        .clk(clk), .rst(rst), .id_valid_i(id_valid), .inst_i(inst), .pc_i(pc), .flush_i(flush),
        .ex_stall_i(hold), .stall_o(a_stall), .id_rs1_addr_o(a_irs1), .id_rs2_addr_o(a_irs2),
        .ex_valid_o(a_valid), .ex_pc_o(a_pc), .ex_rs1_addr_o(a_rs1), .ex_rs2_addr_o(a_rs2),
        .ex_rd_addr_o(a_rd), .ex_imm_o(a_imm), .ALUSrc_B(a_alusrc), .Branch(a_branch), .Jump(a_jump),
        .RegWrite(a_regw), .MemRW(a_memrw), .illegal_o(a_ill), .MemtoReg(a_m2r), .ALU_Control(a_alu),
        .bubble_cnt_o(a_cnt)
    );

    pipeline_id_ex_stage #(.EXT_EN(1'b0), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .id_valid_i(id_valid), .inst_i(inst), .pc_i(pc), .flush_i(flush),
        .ex_stall_i(hold), .stall_o(b_stall), .id_rs1_addr_o(b_irs1), .id_rs2_addr_o(b_irs2),
        .ex_valid_o(b_valid), .ex_pc_o(b_pc), .ex_rs1_addr_o(b_rs1), .ex_rs2_addr_o(b_rs2),
        .ex_rd_addr_o(b_rd), .ex_imm_o(b_imm), .ALUSrc_B(b_alusrc), .Branch(b_branch), .Jump(b_jump),
        .RegWrite(b_regw), .MemRW(b_memrw), .illegal_o(b_ill), .MemtoReg(b_m2r), .ALU_Control(b_alu),
        .bubble_cnt_o(b_cnt)
    );

    bundle_t got0, got1;
    assign got0 = {a_valid, a_pc, a_rs1, a_rs2, a_rd, a_imm, a_alusrc, a_branch, a_jump, a_regw,
                   a_memrw, a_ill, a_m2r, a_alu, a_cnt};
    assign got1 = {b_valid, b_pc, b_rs1, b_rs2, b_rd, b_imm, b_alusrc, b_branch, b_jump, b_regw,
                   b_memrw, b_ill, b_m2r, b_alu, 14'd0, b_cnt};

    task automatic chk(input string nm, input logic [127:0] g, input logic [127:0] e);
        vecs++;
        if (g !== e) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, g, e);
        end
    endtask

    function automatic bundle_t bubble(input logic [15:0] cnt);
        bundle_t b = '0;
        b.alu = 4'h2;
        b.cnt = cnt;
        return b;
    endfunction

    // Reference decode straight from the opcode table; u1/u2 are the source-use flags.
    function automatic bundle_t decode_ref(input logic [31:0] i, input logic [31:0] p, input bit ext,
                                           output bit u1, output bit u2);
        bundle_t e = '0;
        logic [4:0] op;
        logic [2:0] f3;
        logic [3:0] alu_tab [8];
        bit known, ext_only;
        alu_tab = '{4'h2, 4'h8, 4'h7, 4'h9, 4'h3, 4'h5, 4'h1, 4'h0};
        op = i[6:2];
        f3 = i[14:12];
        e.v = 1'b1;
        e.pc = p;
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
        e.rd = i[11:7];
        e.alu = 4'h2;
        e.imm = 32'($signed(i[31:20]));
        u1 = 0;
        u2 = 0;
        known = 1;
        ext_only = (op inside {5'b11001, 5'b01101, 5'b00101}) ||
                   ((op inside {5'b01100, 5'b00100}) && (f3 inside {3'd1, 3'd3, 3'd5}));
        case (op)
            5'b01100: begin
                e.regw = 1; u1 = 1; u2 = 1;
                e.alu = (f3 == 0 && i[30]) ? 4'h6 : (f3 == 5 && i[30]) ? 4'hD : alu_tab[f3];
            end
            5'b00100: begin
                e.alusrc = 1; e.regw = 1; u1 = 1;
                e.alu = (f3 == 5 && i[30]) ? 4'hD : alu_tab[f3];
            end
            5'b00000: begin e.alusrc = 1; e.regw = 1; e.m2r = 2'b01; u1 = 1; end
            5'b01000: begin
                e.alusrc = 1; e.memrw = 1; u1 = 1; u2 = 1;
                e.imm = 32'($signed({i[31:25], i[11:7]}));
            end
            5'b11000: begin
                e.branch = 1; e.alu = 4'h6; u1 = 1; u2 = 1;
                e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            end
            5'b11011: begin
                e.jump = 1; e.regw = 1; e.m2r = 2'b10;
                e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            end
            5'b11001: begin e.jump = 1; e.regw = 1; e.m2r = 2'b10; e.alusrc = 1; u1 = 1; end
            5'b01101: begin e.alusrc = 1; e.regw = 1; e.alu = 4'hA; e.imm = {i[31:12], 12'h000}; end
            5'b00101: begin e.alusrc = 1; e.regw = 1; e.imm = {i[31:12], 12'h000}; end
            default: known = 0;
        endcase
        if (!known || (ext_only && !ext) || i[1:0] != 2'b11) begin
            {e.alusrc, e.branch, e.jump, e.regw, e.memrw, e.m2r} = '0;
            e.alu = 4'h2;
            e.ill = 1;
            u1 = 0;
            u2 = 0;
        end
        return e;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            valid inst          fl    hd    stall valid regw  br    ill   alu    rd     imm            cnt     b_regw b_ill
        tbl[0]  = '{1'b1, 32'h002081B3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h2, 5'd3,  32'h2,        16'd0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 32'h402081B3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h6, 5'd3,  32'h402,      16'd0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 32'h0080A283, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h2, 5'd5,  32'h8,        16'd0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 32'h00128333, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 5'd0,  32'h0,        16'd1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 32'h00128333, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h2, 5'd6,  32'h1,        16'd1, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 32'hFE208EE3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h6, 5'd29, 32'hFFFFFFFC, 16'd1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 32'h123453B7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hA, 5'd7,  32'h12345000, 16'd1, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 32'h0080A283, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h2, 5'd5,  32'h8,        16'd1, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 32'h00128333, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 5'd0,  32'h0,        16'd1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 32'h0080A283, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h2, 5'd5,  32'h8,        16'd1, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 32'h00128333, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h2, 5'd5,  32'h8,        16'd1, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 32'h00128333, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 5'd0,  32'h0,        16'd2, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 32'h00128333, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h2, 5'd6,  32'h1,        16'd2, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 32'h00128333, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 5'd0,  32'h0,        16'd2, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_a", got0, bubble(16'd0));
        chk("reset_b", got1, bubble(16'd0));
        rst = 1'b0;

        for (int n = 0; n < 14; n++) begin
            id_valid = tbl[n].valid;
            inst = tbl[n].inst;
            pc = 32'h100 + 32'(n * 4);
            flush = tbl[n].flush;
            hold = tbl[n].hold;
            #1;
            chk($sformatf("tbl%0d_stall", n), {a_stall, b_stall}, {tbl[n].e_stall, tbl[n].e_stall});
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_a", n), {a_valid, a_regw, a_branch, a_ill, a_alu, a_rd, a_imm, a_cnt},
                {tbl[n].e_valid, tbl[n].e_regw, tbl[n].e_branch, tbl[n].e_ill, tbl[n].e_alu,
                 tbl[n].e_rd, tbl[n].e_imm, tbl[n].e_cnt});
            chk($sformatf("tbl%0d_b", n), {b_valid, b_regw, b_ill, b_cnt},
                {tbl[n].e_valid, tbl[n].b_regw, tbl[n].b_ill, tbl[n].e_cnt[1:0]});
            @(negedge clk);
        end

        // asynchronous reset in the middle of a load-use stall
        id_valid = 1'b1;
        flush = 1'b0;
        hold = 1'b0;
        inst = 32'h0080A283;
        @(posedge clk);
        @(negedge clk);
        inst = 32'h00128333;
        #1;
        chk("pre_rst_stall", a_stall, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_a", got0, bubble(16'd0));
        chk("async_rst_stall", a_stall, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        inst = 32'h002081B3;
        pc = 32'h200;
        #1;
        chk("post_rst_stall", a_stall, 1'b0);
        @(posedge clk);
        #1;
        chk("post_rst_issue", {a_valid, a_regw, a_alu, a_rd, a_pc}, {1'b1, 1'b1, 4'h2, 5'd3, 32'h200});

        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rerst_b", got1, bubble(16'd0));
        m[0] = bubble(16'd0);
        m[1] = bubble(16'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 600; n++) begin
            inst = $urandom;
            inst[6:0] = {ops[$urandom_range(0, 12)], 2'b11};
            inst[11:7] = 5'($urandom_range(0, 3));
            inst[19:15] = 5'($urandom_range(0, 3));
            inst[24:20] = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0) inst[1:0] = 2'b01;
            pc = $urandom;
            id_valid = $urandom_range(0, 9) != 0;
            flush = $urandom_range(0, 9) == 0;
            hold = $urandom_range(0, 6) == 0;
            #1;
            chk("id_addr", {a_irs1, a_irs2}, {inst[19:15], inst[24:20]});
            for (int k = 0; k < 2; k++) begin
                bundle_t d;
                bit u1, u2, lu;
                logic [15:0] c;
                d = decode_ref(inst, pc, k == 0, u1, u2);
                lu = id_valid && m[k].v && m[k].m2r == 2'b01 && m[k].regw && m[k].rd != 0 &&
                     ((u1 && m[k].rd == inst[19:15]) || (u2 && m[k].rd == inst[24:20]));
                chk($sformatf("rnd%0d_stall%0d", n, k), k == 0 ? a_stall : b_stall, !flush && (hold || lu));
                if (flush || !hold) begin
                    c = m[k].cnt;
                    if (!flush && lu && c != (k == 0 ? 16'hFFFF : 16'd3)) c++;
                    m[k] = (id_valid && !flush && !lu) ? d : bubble(16'd0);
                    m[k].cnt = c;
                end
            end
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d_a", n), got0, m[0]);
            chk($sformatf("rnd%0d_b", n), got1, m[1]);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/pipeline_id_ex_stage.md
Name: pipeline_id_ex_stage

Overview:
Registered instruction-decode stage for the 5-stage RV32 pipeline. It decodes the IF/ID instruction and detects load-use hazards against the instruction held in ID/EX. It inserts bubbles and stalls IF, honours flush and downstream hold, and drives a registered ID/EX bundle. It extends the legacy decode with LUI/AUIPC/JALR, shifts and SLTU, a 4-bit ALU_Control and illegal-opcode flagging.

Parameters:
XLEN, 32, datapath/immediate width; must be >= 32; immediates are sign-extended to XLEN.
EXT_EN, 1, 1 = decode LUI/AUIPC/JALR/SLL/SRL/SRA/SLTU; 0 = those opcodes and funct3 values are illegal.
HAZARD_EN, 1, 1 = load-use detection active; 0 = stall_o driven only by ex_stall_i.
CNT_W, 16, width of the saturating bubble counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
id_valid_i  in  1  IF/ID holds a valid instruction
inst_i  in  32  IF/ID instruction
pc_i  in  XLEN  IF/ID PC
flush_i  in  1  EX redirect (taken branch/jump); kill ID contents
ex_stall_i  in  1  downstream hold; ID/EX must not change
stall_o  in/out: out  1  hold PC and IF/ID this cycle (combinational)
id_rs1_addr_o  out  5  inst_i[19:15], combinational, to regfile
id_rs2_addr_o  out  5  inst_i[24:20], combinational, to regfile
ex_valid_o  out  1  registered: ID/EX holds a real instruction
ex_pc_o  out  XLEN  registered PC
ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o  out  5 each  registered register addresses
ex_imm_o  out  XLEN  registered immediate
ALUSrc_B, Branch, Jump, RegWrite, MemRW, illegal_o  out  1 each  registered controls
MemtoReg  out  2  registered: 00 ALU, 01 memory, 10 PC+4
ALU_Control  out  4  registered ALU operation
bubble_cnt_o  out  CNT_W  saturating count of load-use bubbles

Behaviour:
- Reset (async, immediate): all registered outputs are 0 except ALU_Control = 0010. bubble_cnt_o = 0.
- Latency: one cycle from inst_i to the ex_* outputs.
- Decode by inst_i[6:2]; ImmSel selects one of I, S, B, J, U. Every output is defined; there are no x values.
  - R (01100): RegWrite=1.
  - OP-IMM (00100): ALUSrc_B=1, RegWrite=1.
  - LOAD (00000): ALUSrc_B=1, MemtoReg=01, RegWrite=1, ALU add.
  - STORE (01000): ALUSrc_B=1, MemRW=1, ALU add.
  - BRANCH (11000): Branch=1, ALU sub.
  - JAL (11011): Jump=1, RegWrite=1, MemtoReg=10.
  - JALR (11001): same as JAL plus ALUSrc_B=1, I-immediate, ALU add.
  - LUI (01101): ALUSrc_B=1, RegWrite=1, ALU pass-B, U-immediate.
  - AUIPC (00101): ALUSrc_B=1, RegWrite=1, ALU add, U-immediate.
- U-immediate = {inst[31:12], 12'b0}, sign-extended to XLEN.
- ALU_Control encoding (bit3 = 0 keeps the legacy 3-bit codes):
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0101 SRL, 0110 SUB, 0111 SLT.
  - 1000 SLL, 1001 SLTU, 1010 PASS-B, 1101 SRA.
  - funct3 000 with inst[30]=1 on R-type selects SUB; on OP-IMM it selects ADD.
- Illegal opcode, or an EXT-only opcode/funct3 with EXT_EN=0:
  - ex_valid_o=1, illegal_o=1.
  - RegWrite, MemRW, Branch and Jump all 0.
- Source-use flags:
  - rs1 is used by R, OP-IMM, LOAD, STORE, BRANCH and JALR.
  - rs2 is used by R, STORE and BRANCH.
- load_use = HAZARD_EN & id_valid_i & ex_valid_o & (MemtoReg==01) & RegWrite & (ex_rd_addr_o != 0) & ((use_rs1 & ex_rd==rs1) | (use_rs2 & ex_rd==rs2)).
- Per-cycle priority at the clock edge:
  1. flush_i: load a bubble into ID/EX. stall_o=0 and overrides all stall sources.
  2. ex_stall_i: ID/EX holds its value. stall_o=1.
  3. load_use: load a bubble. stall_o=1. bubble_cnt_o increments, saturating at all-ones.
  4. Otherwise: load the decode result with ex_valid_o = id_valid_i. stall_o=0.
- Bubble: ex_valid_o=0, all 1-bit controls 0, MemtoReg 00, ALU_Control 0010. Addresses, immediate and PC are don't-care but held at 0.
- id_valid_i=0 without stall or flush loads a bubble.
- A load-use stall lasts exactly one cycle. On the next cycle the load is no longer in ID/EX, so the dependent instruction issues.
- ex_stall_i together with load_use: holding wins, the bubble is deferred and the counter does not increment.
- Reset asserted mid-stall clears state immediately. The first cycle after reset is a normal load.

Decomposition:
- Shared package pipeline_pkg holds the common typedefs and constants:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - ALU_Control localparams (ALU_AND through ALU_SRA);
  - MemtoReg codes;
  - ImmSel enum (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U).
- One combinational sub-module, id_decoder: inst_i maps to controls, immediate, use flags and illegal. The top holds the hazard logic, the ID/EX register and the counter.

Test Plan:
- add x3,x1,x2 (0x002081B3), then sub (0x402081B3) -> next cycles ALU_Control 0010 then 0110, RegWrite=1, ex_rd_addr_o=3, stall_o=0.
- lw x5,8(x1) (0x0080A283), then add x6,x5,x1 (0x00128333) -> during the add: stall_o=1 for one cycle, a bubble (ex_valid_o=0) is inserted, the add issues a cycle later, bubble_cnt_o=1.
- beq x1,x2,-4 (0xFE208EE3) -> ex_imm_o=0xFFFFFFFC, Branch=1, ALU_Control 0110, RegWrite=0.
- lui x7,0x12345 (0x123453B7) -> EXT_EN=1: ex_imm_o=0x12345000, ALU_Control 1010. EXT_EN=0: illegal_o=1, RegWrite=0.
- load-use pair with flush_i=1 in the same cycle -> stall_o=0, ex_valid_o=0, bubble_cnt_o unchanged. The same pair with ex_stall_i=1 -> ID/EX held.
- rst pulsed asynchronously mid-stall -> outputs clear immediately to reset values. After release, id_valid_i with 0x002081B3 issues one cycle later.
